fpu_sp_accumulator: RTL
=======================

Name: fpu_sp_accumulator

Overview:
- Streaming single-precision accumulator sitting directly downstream of fpu_sp_adder.
- Consumes the adder's result and flag, registers the running sum, and feeds it back as the adder's A operand.
- Incoming operands arrive as packets over a valid/ready stream. One IEEE-754 sum plus a sticky overflow/underflow flag is emitted per packet.
- Instantiates fpu_sp_adder unchanged; the adder stays purely combinational.

Parameters:
- WIDTH, 32, operand/sum width; only 32 supported, kept for symmetry with fpu_sp_adder.
- COUNT_W, 8, width of the per-packet operand counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand valid
- in_ready  output  1  accumulator can accept operand
- in_data  input  WIDTH  IEEE-754 single operand
- in_last  input  1  marks final operand of packet
- out_valid  output  1  packet sum valid
- out_ready  input  1  consumer accepts sum
- out_sum  output  WIDTH  accumulated IEEE-754 sum
- out_count  output  COUNT_W  operands in packet, saturating
- out_ovf_unf  output  1  OR of adder overflow_underflow_flag over packet
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset: asynchronous, clk and rst_n only. All state clears immediately on rst_n low, including mid-packet.
  - Reset values: state=IDLE, acc=32'h0, count=0, sticky=0.
  - Output reset values: out_valid=0, out_sum=0, out_count=0, out_ovf_unf=0, busy=0, in_ready=0 while rst_n low.
- Handshake: transfer occurs when valid && ready on a clk edge.
  - out_valid, out_sum, out_count and out_ovf_unf are held stable until out_ready.
- States: IDLE, ACC, DONE.
- IDLE:
  - in_ready=1.
  - On accept: acc <= in_data (adder bypassed, bits preserved exactly); count <= 1; sticky <= 0.
  - Next state: DONE if in_last, else ACC.
- ACC:
  - in_ready=1; adder A=acc, B=in_data.
  - On accept: acc <= adder result; sticky <= sticky | adder flag; count <= count+1, saturating at 2^COUNT_W-1.
  - Next state: DONE if in_last, else stay in ACC.
  - No accept: everything holds.
- DONE:
  - in_ready=0; out_valid=1; outputs driven from acc, count and sticky.
  - On out_ready: go to IDLE; out_valid drops next cycle.
  - The next packet can be accepted the cycle after the handoff. There is no same-cycle output/input overlap.
- Latency: one cycle per operand. out_valid rises on the cycle after the in_last transfer.
- Throughput: 1 operand/cycle within a packet. Between packets: min 1 DONE cycle plus 1 IDLE cycle.
- Arithmetic: all rounding, special values and flag generation are exactly those of fpu_sp_adder. The accumulator applies no extra normalisation.
- in_last on the first operand gives a single-operand packet: out_sum = in_data bit-exact, count=1, flag=0.
- in_valid is ignored in DONE; upstream must hold its data.

Optional Feature:
- Macro: FPU_ACC_PIPE_EN.
- Defined:
  - A register stage captures the adder result and flag. ACC accept moves to a new state ADD for one cycle, with in_ready=0; ADD writes acc/sticky and returns to ACC, or goes to DONE if the latched last is set.
  - Throughput becomes 1 operand per 2 cycles in ACC. in_last to out_valid latency becomes 2 cycles.
  - Reset clears the pipeline register and latched last.
- Undefined: behaviour exactly as in Behaviour above.

Decomposition:
- Shared package fpu_pkg:
  - state enum typedef (IDLE, ACC, DONE, ADD);
  - SP_WIDTH=32;
  - constants SP_ZERO=32'h0000_0000 and SP_POS_INF=32'h7F80_0000.
- Sub-module: fpu_sp_adder, reused as-is; no new sub-module.

Test Plan:
- 1.0, 2.0, 3.0 (last), out_ready=1 -> out_sum=32'h40C00000 (6.0), out_count=3, out_ovf_unf=0, out_valid 1 cycle after last.
- Single packet 4.2 (32'h40866666) with last -> out_sum=32'h40866666 bit-exact, count=1.
- Packet 3.0e38, 3.0e38 (last) -> out_ovf_unf=1. Next packet 1.0 (last) -> out_ovf_unf=0, confirming sticky is per-packet.
- Backpressure: out_ready low 5 cycles after DONE -> out_valid/out_sum stable, in_ready=0. A packet 2.5, -0.5 offered meanwhile is accepted only after the handoff and yields 2.0 (32'h40000000).
- rst_n pulsed low asynchronously mid-packet after 1.0, 2.0 -> all outputs 0 immediately. Then 5.0 (last) -> out_sum=32'h40A00000, count=1.
- COUNT_W=8, 300 operands of 0.0, last on #300 -> out_count=255 (saturated), out_sum=0.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types and constants for the single-precision FPU blocks.
package fpu_pkg;

    localparam int SP_WIDTH = 32;

    localparam logic [SP_WIDTH-1:0] SP_ZERO    = 32'h0000_0000;
    localparam logic [SP_WIDTH-1:0] SP_POS_INF = 32'h7F80_0000;
    localparam logic [SP_WIDTH-1:0] SP_QNAN    = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2,
        ADD  = 2'd3
    } acc_state_e;

endpackage

// File: rtl/fpu_sp_adder.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even.
// Flag marks overflow to infinity or an inexact subnormal result.
module fpu_sp_adder
    import fpu_pkg::*;
(
    input  logic [SP_WIDTH-1:0] a,
    input  logic [SP_WIDTH-1:0] b,
    output logic [SP_WIDTH-1:0] result,
    output logic                overflow_underflow_flag
);

    logic [31:0] x, y;
    logic [7:0]  ex, ey, ex_n, ey_n, d;
    logic [26:0] ax, ay0, ay, lost;
    logic [27:0] s;
    logic [9:0]  e;
    logic [24:0] mr;
    logic [7:0]  ef;
    logic        sub, g, rs, up, inexact;
    logic        x_nan, y_nan, x_inf, y_inf;

    always_comb begin
        // x always holds the operand of larger magnitude
        x = (a[30:0] >= b[30:0]) ? a : b;
        y = (a[30:0] >= b[30:0]) ? b : a;
        ex = x[30:23];
        ey = y[30:23];
        ex_n = (ex == 8'd0) ? 8'd1 : ex;
        ey_n = (ey == 8'd0) ? 8'd1 : ey;
        d = ex_n - ey_n;
        ax = {ex != 8'd0, x[22:0], 3'b000};
        ay0 = {ey != 8'd0, y[22:0], 3'b000};
        if (d >= 8'd27) begin
            lost = 27'd0;
            ay = {26'd0, |ay0};
        end else begin
            lost = ay0 & ~({27{1'b1}} << d);
            ay = (ay0 >> d) | {26'd0, |lost};
        end

        sub = x[31] ^ y[31];
        if (sub) begin
            s = {1'b0, ax} - {1'b0, ay};
        end else begin
            s = {1'b0, ax} + {1'b0, ay};
        end
        e = {2'b00, ex_n};

        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 10'd1;
        end
        // normalise left, stopping at the subnormal exponent
        for (int i = 0; i < 26; i++) begin
            if (!s[26] && e > 10'd1) begin
                s = s << 1;
                e = e - 10'd1;
            end
        end

        g = s[2];
        rs = s[1] | s[0];
        inexact = g | rs;
        up = g & (rs | s[3]);
        mr = {1'b0, s[26:3]} + {24'd0, up};
        if (mr[24]) begin
            mr = {1'b0, mr[24:1]};
            e = e + 10'd1;
        end
        ef = mr[23] ? e[7:0] : 8'd0;

        x_nan = (ex == 8'hFF) && (x[22:0] != 23'd0);
        y_nan = (ey == 8'hFF) && (y[22:0] != 23'd0);
        x_inf = (ex == 8'hFF) && (x[22:0] == 23'd0);
        y_inf = (ey == 8'hFF) && (y[22:0] == 23'd0);

        overflow_underflow_flag = 1'b0;
        if (x_nan || y_nan || (x_inf && y_inf && sub)) begin
            result = SP_QNAN;
        end else if (x_inf) begin
            result = x;
        end else if (mr[23] && e >= 10'd255) begin
            result = {x[31], SP_POS_INF[30:0]};
            overflow_underflow_flag = 1'b1;
        end else begin
            result = {(mr == 25'd0 && sub) ? 1'b0 : x[31], ef, mr[22:0]};
            overflow_underflow_flag = !mr[23] && inexact;
        end
    end

endmodule

// File: rtl/fpu_sp_accumulator.sv
// Streaming packet accumulator around fpu_sp_adder.
// FPU_ACC_PIPE_EN adds a register stage after the adder (ADD state).
module fpu_sp_accumulator
    import fpu_pkg::*;
#(
    parameter int WIDTH   = SP_WIDTH,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_sum,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_ovf_unf,
    output logic               busy
);

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    acc_state_e         state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [COUNT_W-1:0] count_q, count_d, cnt_inc;
    logic               sticky_q, sticky_d;
    logic [WIDTH-1:0]   add_res;
    logic               add_flag;
    logic               accept;

`ifdef FPU_ACC_PIPE_EN
    logic [WIDTH-1:0]   pipe_sum_q, pipe_sum_d;
    logic               pipe_flag_q, pipe_flag_d;
    logic               last_q, last_d;
`endif

    fpu_sp_adder u_adder (
        .a                       (acc_q),
        .b                       (in_data),
        .result                  (add_res),
        .overflow_underflow_flag (add_flag)
    );

    assign in_ready    = rst_n && (state_q == IDLE || state_q == ACC);
    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign out_sum     = acc_q;
    assign out_count   = count_q;
    assign out_ovf_unf = sticky_q;

    assign accept  = in_valid && in_ready;
    assign cnt_inc = (count_q == CNT_MAX) ? count_q : count_q + COUNT_W'(1);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        count_d  = count_q;
        sticky_d = sticky_q;
`ifdef FPU_ACC_PIPE_EN
        pipe_sum_d  = pipe_sum_q;
        pipe_flag_d = pipe_flag_q;
        last_d      = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d    = in_data;
                    count_d  = COUNT_W'(1);
                    sticky_d = 1'b0;
                    state_d  = in_last ? DONE : ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    count_d = cnt_inc;
`ifdef FPU_ACC_PIPE_EN
                    pipe_sum_d  = add_res;
                    pipe_flag_d = add_flag;
                    last_d      = in_last;
                    state_d     = ADD;
`else
                    acc_d    = add_res;
                    sticky_d = sticky_q | add_flag;
                    state_d  = in_last ? DONE : ACC;
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
`ifdef FPU_ACC_PIPE_EN
            ADD: begin
                acc_d    = pipe_sum_q;
                sticky_d = sticky_q | pipe_flag_q;
                state_d  = last_q ? DONE : ACC;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= SP_ZERO;
            count_q  <= '0;
            sticky_q <= 1'b0;
`ifdef FPU_ACC_PIPE_EN
            pipe_sum_q  <= SP_ZERO;
            pipe_flag_q <= 1'b0;
            last_q      <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
`ifdef FPU_ACC_PIPE_EN
            pipe_sum_q  <= pipe_sum_d;
            pipe_flag_q <= pipe_flag_d;
            last_q      <= last_d;
`endif
        end
    end

endmodule
